// File: rtl/mips_pkg.sv
// Shared definitions for the EX-stage ALU control and multiply/divide unit.
//   ALU select codes, alu_op class codes, R-type funct codes, HI/LO forward
//   select codes and the MDU state enum.
package mips_pkg;

    localparam int unsigned FUNCT_W   = 6;
    localparam int unsigned ALU_SEL_W = 4;
    localparam int unsigned HILO_W    = 2;

    // ALU select codes
    localparam logic [ALU_SEL_W-1:0] ALU_ADD  = 4'h0;
    localparam logic [ALU_SEL_W-1:0] ALU_SUB  = 4'h1;
    localparam logic [ALU_SEL_W-1:0] ALU_AND  = 4'h2;
    localparam logic [ALU_SEL_W-1:0] ALU_OR   = 4'h3;
    localparam logic [ALU_SEL_W-1:0] ALU_SLT  = 4'h4;
    localparam logic [ALU_SEL_W-1:0] ALU_SLL  = 4'h5;
    localparam logic [ALU_SEL_W-1:0] ALU_MUL  = 4'h6;
    localparam logic [ALU_SEL_W-1:0] ALU_DIV  = 4'h7;
    localparam logic [ALU_SEL_W-1:0] ALU_NOR  = 4'h8;
    localparam logic [ALU_SEL_W-1:0] ALU_XOR  = 4'h9;
    localparam logic [ALU_SEL_W-1:0] ALU_SRL  = 4'hA;
    localparam logic [ALU_SEL_W-1:0] ALU_SLTU = 4'hB;
    localparam logic [ALU_SEL_W-1:0] ALU_ILL  = 4'hF;

    // alu_op classes from main control
    localparam logic [2:0] AOP_ADD   = 3'b000;
    localparam logic [2:0] AOP_SUB   = 3'b001;
    localparam logic [2:0] AOP_RTYPE = 3'b010;
    localparam logic [2:0] AOP_SLT   = 3'b100;
    localparam logic [2:0] AOP_AND   = 3'b101;
    localparam logic [2:0] AOP_XOR   = 3'b110;
    localparam logic [2:0] AOP_OR    = 3'b111;

    // R-type funct codes
    localparam logic [FUNCT_W-1:0] F_SLL   = 6'b000000;
    localparam logic [FUNCT_W-1:0] F_SRL   = 6'b000010;
    localparam logic [FUNCT_W-1:0] F_MFHI  = 6'b010000;
    localparam logic [FUNCT_W-1:0] F_MFLO  = 6'b010010;
    localparam logic [FUNCT_W-1:0] F_MULT  = 6'b011000;
    localparam logic [FUNCT_W-1:0] F_MULTU = 6'b011001;
    localparam logic [FUNCT_W-1:0] F_DIV   = 6'b011010;
    localparam logic [FUNCT_W-1:0] F_DIVU  = 6'b011011;
    localparam logic [FUNCT_W-1:0] F_ADD   = 6'b100000;
    localparam logic [FUNCT_W-1:0] F_SUB   = 6'b100010;
    localparam logic [FUNCT_W-1:0] F_AND   = 6'b100100;
    localparam logic [FUNCT_W-1:0] F_OR    = 6'b100101;
    localparam logic [FUNCT_W-1:0] F_XOR   = 6'b100110;
    localparam logic [FUNCT_W-1:0] F_NOR   = 6'b100111;
    localparam logic [FUNCT_W-1:0] F_SLT   = 6'b101010;
    localparam logic [FUNCT_W-1:0] F_SLTU  = 6'b101011;

    // EX result forwarding select
    localparam logic [HILO_W-1:0] HILO_ALU = 2'b00;
    localparam logic [HILO_W-1:0] HILO_HI  = 2'b01;
    localparam logic [HILO_W-1:0] HILO_LO  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/alu_control_mdu_if.sv
// EX-stage bundle between the pipeline (master) and ALU control/MDU (slave).
//   master drives: alu_op, funct, valid, flush, op_a, op_b
//   slave drives : alu_sel, illegal, hilo_sel, stall, busy, hi, lo
interface alu_control_mdu_if #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned ALUOP_W = 3
);
    logic [ALUOP_W-1:0] alu_op;
    logic [5:0]         funct;
    logic               valid;
    logic               flush;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [3:0]         alu_sel;
    logic               illegal;
    logic [1:0]         hilo_sel;
    logic               stall;
    logic               busy;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;

    modport master (
        output alu_op, funct, valid, flush, op_a, op_b,
        input  alu_sel, illegal, hilo_sel, stall, busy, hi, lo
    );

    modport slave (
        input  alu_op, funct, valid, flush, op_a, op_b,
        output alu_sel, illegal, hilo_sel, stall, busy, hi, lo
    );
endinterface

// File: rtl/alu_control_mdu_mdu_iter.sv
// Iterative multiply/divide unit owning HI/LO.
//   start/op_div/op_signed/op_a/op_b : accepted operation (start excludes flush)
//   flush : abort to IDLE, HI/LO untouched
//   busy  : registered, high in RUN and FIX
//   hi/lo : architectural registers, written at the end of FIX
module mdu_iter
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic             op_div,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    mdu_state_e       state_q, state_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;      // product high half / partial remainder
    logic [WIDTH-1:0] mq_q, mq_d;        // multiplier / dividend-quotient
    logic [WIDTH-1:0] opnd_q, opnd_d;    // multiplicand / divisor magnitude
    logic [WIDTH-1:0] a_raw_q, a_raw_d;  // original dividend for divide-by-zero
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             div_q, div_d, neg_q, neg_d, neg_rem_q, neg_rem_d, dz_q, dz_d;

    logic [WIDTH:0]     sum, addend, shifted;
    logic [2*WIDTH-1:0] prod;

    // State and busy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt_q == CNT_W'(1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // Output logic: busy follows the upcoming state so it is a true flop
    always_comb begin
        busy_d = (state_d != IDLE);
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            mq_q      <= '0;
            opnd_q    <= '0;
            a_raw_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            div_q     <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            opnd_q    <= opnd_d;
            a_raw_q   <= a_raw_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            div_q     <= div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
        end
    end

    // Load, one shift-add / restoring-subtract step per RUN cycle, sign fix in FIX
    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        opnd_d    = opnd_q;
        a_raw_d   = a_raw_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        div_d     = div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        sum       = '0;
        addend    = '0;
        shifted   = '0;
        prod      = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d     = CNT_W'(WIDTH);
                    acc_d     = '0;
                    mq_d      = (op_signed && op_a[WIDTH-1]) ? -op_a : op_a;
                    opnd_d    = (op_signed && op_b[WIDTH-1]) ? -op_b : op_b;
                    a_raw_d   = op_a;
                    div_d     = op_div;
                    neg_d     = op_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                    neg_rem_d = op_signed & op_a[WIDTH-1];
                    dz_d      = op_div & (op_b == '0);
                end
            end
            RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (div_q) begin
                    shifted = {acc_q, mq_q[WIDTH-1]};
                    if (shifted >= {1'b0, opnd_q}) begin
                        acc_d = WIDTH'(shifted - {1'b0, opnd_q});
                        mq_d  = {mq_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = shifted[WIDTH-1:0];
                        mq_d  = {mq_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    addend = mq_q[0] ? {1'b0, opnd_q} : '0;
                    sum    = {1'b0, acc_q} + addend;
                    acc_d  = sum[WIDTH:1];
                    mq_d   = {sum[0], mq_q[WIDTH-1:1]};
                end
            end
            FIX: begin
                if (dz_q) begin
                    lo_d = '1;
                    hi_d = a_raw_q;
                end else if (div_q) begin
                    lo_d = neg_q ? -mq_q : mq_q;
                    hi_d = neg_rem_q ? -acc_q : acc_q;
                end else begin
                    prod = {acc_q, mq_q};
                    if (neg_q) prod = -prod;
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
            end
            default: ;
        endcase
        // An aborted operation must not reach the architectural registers
        if (flush) begin
            cnt_d = '0;
            hi_d  = hi_q;
            lo_d  = lo_q;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: rtl/alu_control_mdu.sv
// EX-stage ALU control: decodes alu_op/funct into the ALU select code and
// HI/LO forward select, and issues multiply/divide operations to mdu_iter.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_control_mdu_if slave (operands, decode results, stall, HI/LO)
module alu_control_mdu
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned ALUOP_W = 3
) (
    input logic              clk,
    input logic              rst_n,
    alu_control_mdu_if.slave bus
);
    logic [ALU_SEL_W-1:0] alu_sel_c;
    logic [HILO_W-1:0]    hilo_sel_c;
    logic                 illegal_c;
    logic                 is_mdu, is_mf, mdu_div, mdu_signed;
    logic                 mdu_start, mdu_busy;

    // Decode; anything unrecognised falls through to ALU_ILL
    always_comb begin
        alu_sel_c  = ALU_ILL;
        hilo_sel_c = HILO_ALU;
        illegal_c  = 1'b1;
        is_mdu     = 1'b0;
        is_mf      = 1'b0;
        mdu_div    = 1'b0;
        mdu_signed = 1'b0;
        case (bus.alu_op)
            ALUOP_W'(AOP_ADD): begin alu_sel_c = ALU_ADD; illegal_c = 1'b0; end
            ALUOP_W'(AOP_SUB): begin alu_sel_c = ALU_SUB; illegal_c = 1'b0; end
            ALUOP_W'(AOP_SLT): begin alu_sel_c = ALU_SLT; illegal_c = 1'b0; end
            ALUOP_W'(AOP_AND): begin alu_sel_c = ALU_AND; illegal_c = 1'b0; end
            ALUOP_W'(AOP_XOR): begin alu_sel_c = ALU_XOR; illegal_c = 1'b0; end
            ALUOP_W'(AOP_OR):  begin alu_sel_c = ALU_OR;  illegal_c = 1'b0; end
            ALUOP_W'(AOP_RTYPE): begin
                illegal_c = 1'b0;
                case (bus.funct)
                    F_ADD:   alu_sel_c = ALU_ADD;
                    F_SUB:   alu_sel_c = ALU_SUB;
                    F_AND:   alu_sel_c = ALU_AND;
                    F_OR:    alu_sel_c = ALU_OR;
                    F_SLT:   alu_sel_c = ALU_SLT;
                    F_SLL:   alu_sel_c = ALU_SLL;
                    F_NOR:   alu_sel_c = ALU_NOR;
                    F_XOR:   alu_sel_c = ALU_XOR;
                    F_SRL:   alu_sel_c = ALU_SRL;
                    F_SLTU:  alu_sel_c = ALU_SLTU;
                    F_MULT:  begin alu_sel_c = ALU_MUL; is_mdu = 1'b1; mdu_signed = 1'b1; end
                    F_MULTU: begin alu_sel_c = ALU_MUL; is_mdu = 1'b1; end
                    F_DIV:   begin alu_sel_c = ALU_DIV; is_mdu = 1'b1; mdu_div = 1'b1; mdu_signed = 1'b1; end
                    F_DIVU:  begin alu_sel_c = ALU_DIV; is_mdu = 1'b1; mdu_div = 1'b1; end
                    F_MFHI:  begin alu_sel_c = ALU_ADD; hilo_sel_c = HILO_HI; is_mf = 1'b1; end
                    F_MFLO:  begin alu_sel_c = ALU_ADD; hilo_sel_c = HILO_LO; is_mf = 1'b1; end
                    default: begin alu_sel_c = ALU_ILL; illegal_c = 1'b1; end
                endcase
            end
            default: ;
        endcase
    end

    // HI/LO consumers and new MDU ops wait while an operation is in flight
    assign mdu_start = bus.valid & ~bus.flush & ~mdu_busy & is_mdu;

    mdu_iter #(
        .WIDTH(WIDTH)
    ) u_mdu_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (mdu_start),
        .flush    (bus.flush),
        .op_div   (mdu_div),
        .op_signed(mdu_signed),
        .op_a     (bus.op_a),
        .op_b     (bus.op_b),
        .busy     (mdu_busy),
        .hi       (bus.hi),
        .lo       (bus.lo)
    );

    assign bus.alu_sel  = alu_sel_c;
    assign bus.illegal  = illegal_c;
    assign bus.hilo_sel = hilo_sel_c;
    assign bus.busy     = mdu_busy;
    assign bus.stall    = bus.valid & mdu_busy & (is_mdu | is_mf);

endmodule

// File: tb/tb_alu_control_mdu.sv
// Bench for alu_control_mdu: decode table, MDU arithmetic at WIDTH=32 and WIDTH=8,
// stall/flush/reset behaviour, random operations against an arithmetic model.
module tb_alu_control_mdu;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_control_mdu_if #(.WIDTH(32), .ALUOP_W(3)) b32 ();
    alu_control_mdu_if #(.WIDTH(8),  .ALUOP_W(3)) b8 ();

    alu_control_mdu #(.WIDTH(32), .ALUOP_W(3)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
    alu_control_mdu #(.WIDTH(8),  .ALUOP_W(3)) dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));

    localparam logic [2:0] OP_R     = 3'b010;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MFLO  = 6'b010010;

    typedef struct {
        logic [2:0] op;
        logic [5:0] fn;
        logic [3:0] sel;
        logic [1:0] hs;
        logic       ill;
    } dec_t;

    // Arithmetic reference: native signed/unsigned 64-bit math on w-bit operands
    function automatic void mdu_model(input int w, input bit is_div, input bit sgn,
                                      input longint unsigned a, input longint unsigned b,
                                      output longint unsigned hi_e, output longint unsigned lo_e);
        longint unsigned mask;
        longint sa, sb, p, q, r;
        mask = (64'd1 << w) - 64'd1;
        sa = longint'(a);
        sb = longint'(b);
        if (sgn && a[w-1]) sa = sa - longint'(64'd1 << w);
        if (sgn && b[w-1]) sb = sb - longint'(64'd1 << w);
        if (!is_div) begin
            p    = sa * sb;
            hi_e = ($unsigned(p) >> w) & mask;
            lo_e = $unsigned(p) & mask;
        end else if (b == 0) begin
            lo_e = mask;
            hi_e = a & mask;
        end else begin
            q    = sa / sb;
            r    = sa % sb;
            lo_e = $unsigned(q) & mask;
            hi_e = $unsigned(r) & mask;
        end
    endfunction

    task automatic idle_inputs();
        b32.valid = 1'b0; b32.flush = 1'b0; b32.alu_op = 3'b000; b32.funct = 6'b0;
        b32.op_a = '0; b32.op_b = '0;
        b8.valid = 1'b0; b8.flush = 1'b0; b8.alu_op = 3'b000; b8.funct = 6'b0;
        b8.op_a = '0; b8.op_b = '0;
    endtask

    // Present one MDU op for one cycle; returns at the negedge after the accept edge
    task automatic issue32(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        b32.alu_op = OP_R; b32.funct = f; b32.op_a = a; b32.op_b = b; b32.valid = 1'b1;
        @(negedge clk);
        b32.valid = 1'b0;
    endtask

    task automatic issue8(input logic [5:0] f, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        b8.alu_op = OP_R; b8.funct = f; b8.op_a = a; b8.op_b = b; b8.valid = 1'b1;
        @(negedge clk);
        b8.valid = 1'b0;
    endtask

    // Count busy cycles seen at negedges (bounded)
    task automatic wait32(output int n);
        n = 0;
        while (b32.busy === 1'b1 && n < 200) begin @(negedge clk); n++; end
    endtask

    task automatic wait8(output int n);
        n = 0;
        while (b8.busy === 1'b1 && n < 200) begin @(negedge clk); n++; end
    endtask

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 6))
            0:       return 32'($urandom_range(0, 20));
            1:       return -32'($urandom_range(1, 20));
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'h0;
            default: return 32'($urandom);
        endcase
    endfunction

    function automatic logic [7:0] pick8();
        case ($urandom_range(0, 5))
            0:       return 8'h80;
            1:       return 8'hFF;
            2:       return 8'h00;
            3:       return 8'($urandom_range(1, 5));
            default: return 8'($urandom);
        endcase
    endfunction

    function automatic logic [5:0] op_funct(input int k);
        case (k)
            0:       return FN_MULT;
            1:       return FN_MULTU;
            2:       return FN_DIV;
            default: return FN_DIVU;
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        checks++;
        if (b32.busy !== 1'b0 || b32.hi !== 32'h0 || b32.lo !== 32'h0 || b32.stall !== 1'b0) begin
            errors++;
            $display("FAIL reset32: busy=%b hi=%h lo=%h stall=%b, want 0/0/0/0", b32.busy, b32.hi, b32.lo, b32.stall);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (b8.busy !== 1'b0 || b8.hi !== 8'h0 || b8.lo !== 8'h0) begin
            errors++;
            $display("FAIL reset8: busy=%b hi=%h lo=%h, want 0/00/00", b8.busy, b8.hi, b8.lo);
        end
    endtask

    task automatic test_decode();
        dec_t t [25];
        logic [5:0] fn;
        t = '{
            '{3'b000, 6'h00, 4'h0, 2'b00, 1'b0}, '{3'b001, 6'h00, 4'h1, 2'b00, 1'b0},
            '{3'b100, 6'h00, 4'h4, 2'b00, 1'b0}, '{3'b101, 6'h00, 4'h2, 2'b00, 1'b0},
            '{3'b110, 6'h00, 4'h9, 2'b00, 1'b0}, '{3'b111, 6'h00, 4'h3, 2'b00, 1'b0},
            '{3'b011, 6'h00, 4'hF, 2'b00, 1'b1},
            '{3'b010, 6'b100000, 4'h0, 2'b00, 1'b0}, '{3'b010, 6'b100010, 4'h1, 2'b00, 1'b0},
            '{3'b010, 6'b100100, 4'h2, 2'b00, 1'b0}, '{3'b010, 6'b100101, 4'h3, 2'b00, 1'b0},
            '{3'b010, 6'b101010, 4'h4, 2'b00, 1'b0}, '{3'b010, 6'b000000, 4'h5, 2'b00, 1'b0},
            '{3'b010, 6'b011000, 4'h6, 2'b00, 1'b0}, '{3'b010, 6'b011010, 4'h7, 2'b00, 1'b0},
            '{3'b010, 6'b100111, 4'h8, 2'b00, 1'b0}, '{3'b010, 6'b100110, 4'h9, 2'b00, 1'b0},
            '{3'b010, 6'b000010, 4'hA, 2'b00, 1'b0}, '{3'b010, 6'b101011, 4'hB, 2'b00, 1'b0},
            '{3'b010, 6'b011001, 4'h6, 2'b00, 1'b0}, '{3'b010, 6'b011011, 4'h7, 2'b00, 1'b0},
            '{3'b010, 6'b010000, 4'h0, 2'b01, 1'b0}, '{3'b010, 6'b010010, 4'h0, 2'b10, 1'b0},
            '{3'b010, 6'b111111, 4'hF, 2'b00, 1'b1}, '{3'b010, 6'b100001, 4'hF, 2'b00, 1'b1}
        };
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            // non-R classes must ignore funct entirely
            fn = (t[i].op != OP_R) ? 6'($urandom) : t[i].fn;
            b32.alu_op = t[i].op; b32.funct = fn; b32.valid = 1'b0;
            b8.alu_op  = t[i].op; b8.funct  = fn; b8.valid  = 1'b0;
            #1;
            checks++;
            if (b32.alu_sel !== t[i].sel || b32.illegal !== t[i].ill || b32.hilo_sel !== t[i].hs) begin
                errors++;
                $display("FAIL decode32[%0d] op=%b fn=%b: sel=%h ill=%b hs=%b, want sel=%h ill=%b hs=%b",
                         i, t[i].op, fn, b32.alu_sel, b32.illegal, b32.hilo_sel, t[i].sel, t[i].ill, t[i].hs);
            end
            checks++;
            if (b8.alu_sel !== t[i].sel || b8.illegal !== t[i].ill || b8.hilo_sel !== t[i].hs) begin
                errors++;
                $display("FAIL decode8[%0d] op=%b fn=%b: sel=%h ill=%b hs=%b, want sel=%h ill=%b hs=%b",
                         i, t[i].op, fn, b8.alu_sel, b8.illegal, b8.hilo_sel, t[i].sel, t[i].ill, t[i].hs);
            end
        end
        idle_inputs();
    endtask

    task automatic test_mult();
        int n;
        issue32(FN_MULT, 32'hFFFF_FFFD, 32'd7);
        wait32(n);
        checks++;
        if (n != 33 || b32.busy !== 1'b0 || b32.hi !== 32'hFFFF_FFFF || b32.lo !== 32'hFFFF_FFEB) begin
            errors++;
            $display("FAIL mult_-3x7: cycles=%0d busy=%b hi=%h lo=%h, want 33/0/FFFFFFFF/FFFFFFEB",
                     n, b32.busy, b32.hi, b32.lo);
        end
    endtask

    task automatic test_div();
        logic [5:0]  f  [4] = '{FN_DIVU, FN_DIV, FN_DIV, FN_DIV};
        logic [31:0] a  [4] = '{32'd100, 32'hFFFF_FFF9, 32'd5, 32'h8000_0000};
        logic [31:0] b  [4] = '{32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF};
        logic [31:0] eh [4] = '{32'd2, 32'hFFFF_FFFF, 32'd5, 32'd0};
        logic [31:0] el [4] = '{32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
        int n;
        for (int i = 0; i < 4; i++) begin
            issue32(f[i], a[i], b[i]);
            wait32(n);
            checks++;
            if (n != 33 || b32.hi !== eh[i] || b32.lo !== el[i]) begin
                errors++;
                $display("FAIL div[%0d] %h/%h: cycles=%0d hi=%h lo=%h, want 33/%h/%h",
                         i, a[i], b[i], n, b32.hi, b32.lo, eh[i], el[i]);
            end
        end
    endtask

    task automatic test_mflo_stall();
        longint unsigned eh, el;
        int stalled, bad, n;
        mdu_model(32, 1'b0, 1'b1, 64'h0001_2345, 64'hFFFF_FF00, eh, el);
        issue32(FN_MULT, 32'h0001_2345, 32'hFFFF_FF00);
        @(negedge clk);
        // unrelated ALU op while busy: decoded, not stalled
        b32.alu_op = OP_R; b32.funct = FN_ADD; b32.valid = 1'b1;
        #1;
        checks++;
        if (b32.stall !== 1'b0 || b32.alu_sel !== 4'h0 || b32.busy !== 1'b1) begin
            errors++;
            $display("FAIL add_while_busy: stall=%b sel=%h busy=%b, want 0/0/1", b32.stall, b32.alu_sel, b32.busy);
        end
        @(negedge clk);
        b32.funct = FN_MFLO;
        #1;
        stalled = 0; bad = 0; n = 0;
        while (b32.busy === 1'b1 && n < 200) begin
            stalled++;
            if (b32.stall !== 1'b1) bad++;
            @(negedge clk);
            n++;
        end
        checks++;
        if (stalled != 31 || bad != 0) begin
            errors++;
            $display("FAIL mflo_stall: stalled=%0d bad=%0d, want 31/0", stalled, bad);
        end
        checks++;
        if (b32.stall !== 1'b0 || b32.hilo_sel !== 2'b10 || b32.lo !== 32'(el) || b32.hi !== 32'(eh)) begin
            errors++;
            $display("FAIL mflo_release: stall=%b hs=%b hi=%h lo=%h, want 0/10/%h/%h",
                     b32.stall, b32.hilo_sel, b32.hi, b32.lo, 32'(eh), 32'(el));
        end
        idle_inputs();
    endtask

    task automatic test_flush();
        int n;
        issue32(FN_MULT, 32'd6, 32'd7);
        wait32(n);
        checks++;
        if (n != 33 || b32.hi !== 32'd0 || b32.lo !== 32'd42) begin
            errors++;
            $display("FAIL mult_6x7: cycles=%0d hi=%h lo=%h, want 33/0/2a", n, b32.hi, b32.lo);
        end
        issue32(FN_MULTU, 32'h0001_2345, 32'h0000_6789);
        repeat (9) @(negedge clk);
        b32.flush = 1'b1;
        @(negedge clk);
        b32.flush = 1'b0;
        checks++;
        if (b32.busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_run: busy=%b, want 0", b32.busy);
        end
        repeat (40) @(negedge clk);
        checks++;
        if (b32.busy !== 1'b0 || b32.hi !== 32'd0 || b32.lo !== 32'd42) begin
            errors++;
            $display("FAIL flush_hilo: busy=%b hi=%h lo=%h, want 0/0/2a", b32.busy, b32.hi, b32.lo);
        end
        // flush in the accept cycle cancels the start
        b32.alu_op = OP_R; b32.funct = FN_DIVU; b32.op_a = 32'd9; b32.op_b = 32'd2;
        b32.valid = 1'b1; b32.flush = 1'b1;
        @(negedge clk);
        idle_inputs();
        checks++;
        if (b32.busy !== 1'b0 || b32.lo !== 32'd42) begin
            errors++;
            $display("FAIL flush_accept: busy=%b lo=%h, want 0/2a", b32.busy, b32.lo);
        end
    endtask

    task automatic test_reset_mid_run();
        issue32(FN_DIVU, 32'd1000, 32'd3);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (b32.busy !== 1'b0 || b32.hi !== 32'd0 || b32.lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_run: busy=%b hi=%h lo=%h, want 0/0/0", b32.busy, b32.hi, b32.lo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (b32.busy !== 1'b0 || b32.lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_no_resume: busy=%b lo=%h, want 0/0", b32.busy, b32.lo);
        end
    endtask

    task automatic test_random32();
        longint unsigned eh, el;
        logic [31:0] a, b;
        int k, n;
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 3);
            a = pick32();
            b = pick32();
            mdu_model(32, k >= 2, (k % 2) == 0, 64'(a), 64'(b), eh, el);
            issue32(op_funct(k), a, b);
            wait32(n);
            checks++;
            if (n != 33 || b32.hi !== 32'(eh) || b32.lo !== 32'(el)) begin
                errors++;
                $display("FAIL rand32[%0d] k=%0d %h,%h: cycles=%0d hi=%h lo=%h, want 33/%h/%h",
                         i, k, a, b, n, b32.hi, b32.lo, 32'(eh), 32'(el));
            end
        end
    endtask

    task automatic test_w8_multu();
        int n;
        issue8(FN_MULTU, 8'hFF, 8'hFF);
        wait8(n);
        checks++;
        if (n != 9 || b8.busy !== 1'b0 || b8.hi !== 8'hFE || b8.lo !== 8'h01) begin
            errors++;
            $display("FAIL w8_multu_255x255: cycles=%0d busy=%b hi=%h lo=%h, want 9/0/FE/01",
                     n, b8.busy, b8.hi, b8.lo);
        end
    endtask

    task automatic test_w8_random();
        longint unsigned eh, el;
        logic [7:0] a, b;
        int k, n;
        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 3);
            a = pick8();
            b = pick8();
            mdu_model(8, k >= 2, (k % 2) == 0, 64'(a), 64'(b), eh, el);
            issue8(op_funct(k), a, b);
            wait8(n);
            checks++;
            if (n != 9 || b8.hi !== 8'(eh) || b8.lo !== 8'(el)) begin
                errors++;
                $display("FAIL rand8[%0d] k=%0d %h,%h: cycles=%0d hi=%h lo=%h, want 9/%h/%h",
                         i, k, a, b, n, b8.hi, b8.lo, 8'(eh), 8'(el));
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_decode();
        test_mult();
        test_div();
        test_mflo_stall();
        test_flush();
        test_reset_mid_run();
        test_random32();
        test_w8_multu();
        test_w8_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
